// File: rtl/sample_window_pkg.sv
// Shared types and constants for the sample window counter.
// Contents: FSM state enum, mode encodings, wrap counter width.
package sample_window_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    localparam logic        MODE_WRAP = 1'b0;
    localparam logic        MODE_SAT  = 1'b1;
    localparam int unsigned WRAPCNT_W = 8;

endpackage

// File: rtl/sample_window_ctr.sv
// Sample window counter: counts cycles up to a latched terminal value, then
// either wraps or saturates and holds, with a one-clock terminal-count pulse.
//
// Ports:
//   clk       - rising-edge clock
//   reset     - asynchronous active-low reset
//   cycle     - 1 = keep counting, 0 = abandon the current window
//   clear     - synchronous clear, overrides all other inputs
//   limit     - terminal count for the next window (0 selects DEFAULT_LIMIT)
//   mode      - 0 = wrap, 1 = saturate-and-hold
//   ctr       - current count (registered)
//   tc        - terminal-count pulse (registered)
//   wrap_cnt  - saturating count of tc pulses (only with SAMPLE_WINDOW_CTR_WRAPCNT_EN)
//   busy      - high while in RUN or HOLD (registered)
//
// Build option: define SAMPLE_WINDOW_CTR_WRAPCNT_EN to add the wrap_cnt output.
module sample_window_ctr
    import sample_window_pkg::*;
#(
    parameter int unsigned      WIDTH         = 5,
    parameter logic [WIDTH-1:0] DEFAULT_LIMIT = {WIDTH{1'b1}}
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cycle,
    input  logic                 clear,
    input  logic [WIDTH-1:0]     limit,
    input  logic                 mode,
    output logic [WIDTH-1:0]     ctr,
    output logic                 tc,
`ifdef SAMPLE_WINDOW_CTR_WRAPCNT_EN
    output logic [WRAPCNT_W-1:0] wrap_cnt,
`endif
    output logic                 busy
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_ctr;
    logic [WIDTH-1:0] w_ctr_nxt;
    logic [WIDTH-1:0] r_limit_q;
    logic [WIDTH-1:0] w_limit_nxt;
    logic             r_mode_q;
    logic             w_mode_nxt;
    logic             r_tc;
    logic             w_tc_nxt;
    logic             r_busy;
    logic [WIDTH-1:0] w_ctr_inc;
    logic [WIDTH-1:0] w_limit_map;
    logic             w_at_limit;

    // Increment is only used while r_ctr < r_limit_q, so it cannot overflow.
    assign w_ctr_inc   = r_ctr + WIDTH'(1);
    assign w_limit_map = (limit == '0) ? DEFAULT_LIMIT : limit;
    assign w_at_limit  = (r_ctr == r_limit_q);

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_ctr     <= '0;
            r_tc      <= 1'b0;
            r_busy    <= 1'b0;
            r_limit_q <= DEFAULT_LIMIT;
            r_mode_q  <= MODE_WRAP;
        end else begin
            r_state   <= w_state_nxt;
            r_ctr     <= w_ctr_nxt;
            r_tc      <= w_tc_nxt;
            r_busy    <= (w_state_nxt != S_IDLE);
            r_limit_q <= w_limit_nxt;
            r_mode_q  <= w_mode_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        if (clear) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: if (cycle) w_state_nxt = S_RUN;
                S_RUN: begin
                    if (!cycle) begin
                        w_state_nxt = S_IDLE;
                    end else if (w_at_limit && (r_mode_q == MODE_SAT)) begin
                        w_state_nxt = S_HOLD;
                    end
                end
                S_HOLD: if (!cycle) w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Next values for counter, pulse and latched window configuration.
    always_comb begin
        w_ctr_nxt   = r_ctr;
        w_tc_nxt    = 1'b0;
        w_limit_nxt = r_limit_q;
        w_mode_nxt  = r_mode_q;
        if (clear) begin
            w_ctr_nxt = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_ctr_nxt = '0;
                    if (cycle) begin
                        w_limit_nxt = w_limit_map;
                        w_mode_nxt  = mode;
                    end
                end
                S_RUN: begin
                    if (!cycle) begin
                        w_ctr_nxt = '0;
                    end else if (!w_at_limit) begin
                        w_ctr_nxt = w_ctr_inc;
                        w_tc_nxt  = (w_ctr_inc == r_limit_q);
                    end else if (r_mode_q == MODE_WRAP) begin
                        w_ctr_nxt = '0;
                    end
                end
                S_HOLD: if (!cycle) w_ctr_nxt = '0;
                default: w_ctr_nxt = '0;
            endcase
        end
    end

`ifdef SAMPLE_WINDOW_CTR_WRAPCNT_EN
    logic [WRAPCNT_W-1:0] r_wrap_cnt;

    // Counts tc pulses as they are issued; sticks at all-ones.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wrap_cnt <= '0;
        end else if (clear) begin
            r_wrap_cnt <= '0;
        end else if (w_tc_nxt && (r_wrap_cnt != '1)) begin
            r_wrap_cnt <= r_wrap_cnt + WRAPCNT_W'(1);
        end
    end

    assign wrap_cnt = r_wrap_cnt;
`else
    // No tc pulse counter in this build.
`endif

    assign ctr  = r_ctr;
    assign tc   = r_tc;
    assign busy = r_busy;

endmodule

// File: tb/tb_sample_window_ctr.sv
// Self-checking bench for sample_window_ctr (WIDTH=5): directed scenarios plus
// randomized stimulus against a window-age reference model.
module tb_sample_window_ctr;

    localparam int unsigned WIDTH   = 5;
    localparam int          DEF_LIM = 31;

    logic             clk   = 1'b0;
    logic             reset = 1'b0;
    logic             cycle = 1'b0;
    logic             clear = 1'b0;
    logic             mode  = 1'b0;
    logic [WIDTH-1:0] limit = '0;
    logic [WIDTH-1:0] ctr;
    logic             tc;
    logic             busy;
`ifdef SAMPLE_WINDOW_CTR_WRAPCNT_EN
    logic [7:0]       wrap_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a window is armed or not; age counts clocks since arming.
    bit m_armed = 1'b0;
    bit m_sat   = 1'b0;
    int m_age   = 0;
    int m_lim   = DEF_LIM;
    int m_wc    = 0;

    always #5 clk = ~clk;

    sample_window_ctr #(
        .WIDTH(WIDTH)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .cycle   (cycle),
        .clear   (clear),
        .limit   (limit),
        .mode    (mode),
        .ctr     (ctr),
        .tc      (tc),
`ifdef SAMPLE_WINDOW_CTR_WRAPCNT_EN
        .wrap_cnt(wrap_cnt),
`endif
        .busy    (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int exp_ctr();
        if (!m_armed) return 0;
        if (m_sat) return (m_age < m_lim) ? m_age : m_lim;
        return m_age % (m_lim + 1);
    endfunction

    function automatic int exp_tc();
        if (!m_armed || m_age == 0) return 0;
        if (m_sat) return (m_age == m_lim) ? 1 : 0;
        return ((m_age % (m_lim + 1)) == m_lim) ? 1 : 0;
    endfunction

    task automatic model_reset();
        m_armed = 1'b0;
        m_sat   = 1'b0;
        m_age   = 0;
        m_lim   = DEF_LIM;
        m_wc    = 0;
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        if (clear) begin
            m_armed = 1'b0;
            m_age   = 0;
        end else if (!m_armed) begin
            if (cycle) begin
                m_armed = 1'b1;
                m_age   = 0;
                m_lim   = (limit == '0) ? DEF_LIM : int'(limit);
                m_sat   = mode;
            end
        end else if (!cycle) begin
            m_armed = 1'b0;
            m_age   = 0;
        end else begin
            m_age++;
        end
        if (clear) m_wc = 0;
        else if (exp_tc() != 0 && m_wc < 255) m_wc++;
    endtask

    task automatic compare_all(input string tag);
        check({tag, "/ctr"},  32'(ctr),  32'(exp_ctr()));
        check({tag, "/tc"},   32'(tc),   32'(exp_tc()));
        check({tag, "/busy"}, 32'(busy), 32'(m_armed));
`ifdef SAMPLE_WINDOW_CTR_WRAPCNT_EN
        check({tag, "/wrap_cnt"}, 32'(wrap_cnt), 32'(m_wc));
`endif
    endtask

    task automatic tick(input string tag);
        model_step();
        @(posedge clk);
        #1;
        compare_all(tag);
    endtask

    // Pulse reset between edges and check the outputs react without a clock.
    task automatic async_reset(input string tag);
        reset = 1'b0;
        #1;
        model_reset();
        compare_all(tag);
        reset = 1'b1;
    endtask

    task automatic go_idle();
        cycle = 1'b0;
        clear = 1'b0;
        tick("idle");
    endtask

    initial begin
        int first_tc;
        int second_tc;
        int n_tc;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        compare_all("reset");
        reset = 1'b1;

        // Default limit, wrap mode: 32-clock period
        go_idle();
        limit = '0; mode = 1'b0; cycle = 1'b1;
        first_tc = -1; second_tc = -1;
        for (int i = 1; i <= 70; i++) begin
            tick("r029");
            if (tc === 1'b1) begin
                if (first_tc < 0) first_tc = i;
                else if (second_tc < 0) second_tc = i;
            end
        end
        check("r029_first_tc", 32'(first_tc), 32'd32);
        check("r029_period", 32'(second_tc - first_tc), 32'd32);

        // Asynchronous reset mid-window at ctr=17
        go_idle();
        limit = '0; mode = 1'b0; cycle = 1'b1;
        repeat (18) tick("r028_run");
        check("r028_pre_ctr", 32'(ctr), 32'd17);
        async_reset("r028");
        check("r028_ctr", 32'(ctr), 32'd0);
        check("r028_busy", 32'(busy), 32'd0);

        // Saturate at 9, limit change while holding is ignored
        go_idle();
        limit = 5'd9; mode = 1'b1; cycle = 1'b1;
        n_tc = 0;
        repeat (15) begin
            tick("r030");
            if (tc === 1'b1) n_tc++;
        end
        check("r030_tc_count", 32'(n_tc), 32'd1);
        check("r030_hold_ctr", 32'(ctr), 32'd9);
        limit = 5'd4; mode = 1'b0;
        repeat (5) tick("r030_chg");
        check("r030_hold_after_chg", 32'(ctr), 32'd9);

        // Abandon at ctr=5, re-arm with limit 3
        go_idle();
        limit = '0; mode = 1'b0; cycle = 1'b1;
        repeat (6) tick("r031_run");
        check("r031_pre_ctr", 32'(ctr), 32'd5);
        cycle = 1'b0;
        tick("r031_drop");
        check("r031_drop_busy", 32'(busy), 32'd0);
        cycle = 1'b1; limit = 5'd3;
        tick("r031_arm");
        check("r031_arm_ctr", 32'(ctr), 32'd0);
        for (int v = 1; v <= 3; v++) begin
            tick("r031_cnt");
            check("r031_ctr", 32'(ctr), 32'(v));
            check("r031_tc", 32'(tc), (v == 3) ? 32'd1 : 32'd0);
        end

        // Clear overrides cycle at ctr=20
        go_idle();
        limit = '0; mode = 1'b0; cycle = 1'b1;
        repeat (21) tick("r032_run");
        check("r032_pre_ctr", 32'(ctr), 32'd20);
        clear = 1'b1;
        tick("r032_clr");
        check("r032_clr_busy", 32'(busy), 32'd0);
        check("r032_clr_ctr", 32'(ctr), 32'd0);
        clear = 1'b0;
        tick("r032_arm");
        check("r032_arm_busy", 32'(busy), 32'd1);
        tick("r032_cnt");
        check("r032_cnt_ctr", 32'(ctr), 32'd1);

`ifdef SAMPLE_WINDOW_CTR_WRAPCNT_EN
        // Wrap counter rises every 2 clocks with limit 1 and saturates
        cycle = 1'b0; clear = 1'b1;
        tick("r033_clr");
        clear = 1'b0; limit = 5'd1; mode = 1'b0; cycle = 1'b1;
        repeat (21) tick("r033");
        check("r033_mid", 32'(wrap_cnt), 32'd10);
        repeat (579) tick("r033");
        check("r033_sat", 32'(wrap_cnt), 32'd255);
`endif

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cycle = ($urandom_range(0, 39) != 0);
            clear = ($urandom_range(0, 59) == 0);
            mode  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) limit = 5'($urandom_range(0, 31));
            else                           limit = 5'($urandom_range(0, 6));
            if ($urandom_range(0, 199) == 0) async_reset("rnd_rst");
            else                             tick("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sample_window_ctr.md
SAMPLE_WINDOW_CTR -- requirements
Module: sample_window_ctr

Interface
REQ-001 The module SHALL have parameter WIDTH, default 5, counter and limit width in bits (legal 2..16).
REQ-002 The module SHALL have parameter DEFAULT_LIMIT, default 2**WIDTH-1, terminal value used when limit input is 0.
REQ-003 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port reset  input  1  one clock; reset is asynchronous and active-low (asserted at 0).
REQ-005 Port cycle  input  1  count request; high = keep counting, low = abandon window.
REQ-006 Port clear  input  1  synchronous clear, active-high.
REQ-007 Port limit  input  WIDTH  terminal count for the next window; 0 selects DEFAULT_LIMIT.
REQ-008 Port mode  input  1  0 = wrap, 1 = saturate-and-hold.
REQ-009 Port ctr  output  WIDTH  current count, registered.
REQ-010 Port tc  output  1  terminal-count pulse, registered.
REQ-011 Port busy  output  1  high in RUN or HOLD.

Function
REQ-012 The block SHALL implement states IDLE, RUN, HOLD.
REQ-013 IDLE: ctr SHALL be 0; cycle=1 SHALL latch limit (0 mapped to DEFAULT_LIMIT) and mode into limit_q/mode_q and enter RUN with ctr unchanged (one-cycle arm latency).
REQ-014 RUN, cycle=1, ctr<limit_q: ctr SHALL increment by 1 per clock.
REQ-015 tc SHALL be 1 for exactly the clock in which ctr equals limit_q after an increment, 0 otherwise.
REQ-016 RUN, ctr==limit_q, cycle=1, mode_q=0: ctr SHALL wrap to 0 on the next edge and stay in RUN; period = limit_q+1 clocks.
REQ-017 RUN, ctr==limit_q, cycle=1, mode_q=1: block SHALL enter HOLD with ctr held at limit_q; tc not reasserted.
REQ-018 RUN or HOLD with cycle=0: next edge SHALL give ctr=0, tc=0, state IDLE.
REQ-019 limit and mode changes while busy SHALL be ignored until the next IDLE->RUN transition.
REQ-020 clear=1 SHALL override every other input: next edge ctr=0, tc=0, state IDLE, limit_q unchanged.
REQ-021 Arithmetic SHALL be unsigned WIDTH-bit; ctr SHALL never exceed limit_q and SHALL never overflow silently.

Reset
REQ-022 reset=0 SHALL immediately, without clk, force ctr=0, tc=0, busy=0, state IDLE, limit_q=DEFAULT_LIMIT, mode_q=0.
REQ-023 Reset deassertion SHALL take effect on the first clk edge after release; reset mid-window SHALL discard the window.

Configuration
REQ-024 With SAMPLE_WINDOW_CTR_WRAPCNT_EN defined, the block SHALL add output wrap_cnt (8 bits), counting tc pulses, saturating at 255, cleared by reset and clear, and held when cycle=0.
REQ-025 Without SAMPLE_WINDOW_CTR_WRAPCNT_EN, port wrap_cnt and its logic SHALL be absent; all other behaviour identical.

Structure
REQ-026 Package sample_window_pkg SHALL hold the state enum typedef (S_IDLE, S_RUN, S_HOLD), constants MODE_WRAP=0, MODE_SAT=1, WRAPCNT_W=8.
REQ-027 The block SHALL be a single module; no sub-module is required.

Verification (WIDTH=5)
REQ-028 reset=0 while ctr=17 in RUN -> ctr=0, tc=0, busy=0 before the next clk edge.
REQ-029 limit=0, mode=0, cycle=1 for 70 clocks -> one arm clock, ctr 0..31, tc at ctr=31, wrap to 0, second tc exactly 32 clocks after the first.
REQ-030 limit=9, mode=1, cycle=1 -> ctr reaches 9, one tc pulse, ctr holds 9 in HOLD; limit changed to 4 mid-hold has no effect.
REQ-031 cycle dropped at ctr=5 -> next edge ctr=0, IDLE; reassert with limit=3 -> arm clock, then 1,2,3 with tc at 3.
REQ-032 clear=1 with cycle=1 at ctr=20 -> next edge ctr=0, IDLE, tc=0; clear released -> re-arm and count from 0.
REQ-033 With SAMPLE_WINDOW_CTR_WRAPCNT_EN, limit=1, mode=0, cycle=1 for 600 clocks -> wrap_cnt rises by 1 per 2 clocks and saturates at 255.
